// File: rtl/stream_reduction_unit.sv
// Frame-wide bitwise reduction engine: folds 1..BEATS words into a column accumulator
// and a scalar AND/NAND/OR/NOR/XOR/XNOR result, presented on a held valid/ready output.
module stream_reduction_unit #(
    parameter int WIDTH = 32,
    parameter int BEATS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    input  logic [2:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_bit,
    output logic [WIDTH-1:0]             out_word,
    output logic [$clog2(BEATS+1)-1:0]   out_beats,
    output logic                         out_err
);

    localparam int             CW      = $clog2(BEATS + 1);
    localparam logic [CW-1:0]  BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        mode_q, mode_d;

    logic              out_valid_q, out_valid_d;
    logic              out_bit_q, out_bit_d;
    logic [WIDTH-1:0]  out_word_q, out_word_d;
    logic [CW-1:0]     out_beats_q, out_beats_d;
    logic              out_err_q, out_err_d;

    logic              beat;
    logic [2:0]        mode_eff;
    logic [WIDTH-1:0]  acc_next;
    logic [CW-1:0]     cnt_next;
    logic              frame_end;

    // Illegal modes (6/7) fall into the XOR accumulator path.
    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       m);
        logic [WIDTH-1:0] r;
        case (m)
            3'd0, 3'd1: r = a & b;
            3'd2, 3'd3: r = a | b;
            default:    r = a ^ b;
        endcase
        return r;
    endfunction

    function automatic logic reduce(input logic [WIDTH-1:0] a,
                                    input logic [2:0]       m);
        logic r;
        case (m)
            3'd0:    r = &a;
            3'd1:    r = ~&a;
            3'd2:    r = |a;
            3'd3:    r = ~|a;
            3'd4:    r = ^a;
            3'd5:    r = ~^a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(input logic [2:0] m);
        return m[2] & m[1];
    endfunction

    assign in_ready = (state_q != S_DONE);
    assign beat     = in_valid && in_ready;

    // The first beat of a frame carries the mode; later beats use the latched copy.
    always_comb begin
        mode_eff  = (state_q == S_IDLE) ? in_mode : mode_q;
        acc_next  = (state_q == S_IDLE) ? in_data : combine(acc_q, in_data, mode_eff);
        cnt_next  = (state_q == S_IDLE) ? ONE_C : cnt_q + ONE_C;
        frame_end = in_last || (cnt_next == BEATS_C);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_bit_d   = out_bit_q;
        out_word_d  = out_word_q;
        out_beats_d = out_beats_q;
        out_err_d   = out_err_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (beat) begin
                    mode_d = mode_eff;
                    acc_d  = acc_next;
                    cnt_d  = cnt_next;
                    if (frame_end) begin
                        state_d     = S_DONE;
                        out_word_d  = acc_next;
                        out_beats_d = cnt_next;
                        out_bit_d   = reduce(acc_next, mode_eff);
                        out_err_d   = is_illegal(mode_eff);
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_word_q  <= '0;
            out_beats_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_word_q  <= out_word_d;
            out_beats_q <= out_beats_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_word  = out_word_q;
    assign out_beats = out_beats_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_stream_reduction_unit.sv
// Bench for stream_reduction_unit: directed vector table, multi-cycle corner sequences,
// and randomized frames against a popcount-based reference model.
module tb_stream_reduction_unit;

    localparam int W = 32;
    localparam int B = 4;

    typedef logic [W-1:0] word_arr_t [B];

    typedef struct {
        logic [2:0]   mode;
        int           n;
        word_arr_t    d;
        logic         eb;
        logic [W-1:0] ew;
        int           ebeats;
        logic         ee;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, in_last, out_valid, out_ready, out_bit, out_err;
    logic [W-1:0] in_data, out_word;
    logic [2:0]   in_mode;
    logic [2:0]   out_beats;

    logic         s_reset, s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_bit, s_out_err;
    logic [2:0]   s_in_data, s_out_word;
    logic [2:0]   s_in_mode;
    logic [0:0]   s_out_beats;

    stream_reduction_unit #(.WIDTH(W), .BEATS(B)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_word(out_word), .out_beats(out_beats), .out_err(out_err)
    );

    stream_reduction_unit #(.WIDTH(3), .BEATS(1)) dut_small (
        .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_last(s_in_last), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bit(s_out_bit),
        .out_word(s_out_word), .out_beats(s_out_beats), .out_err(s_out_err)
    );

    int   checks = 0;
    int   failures = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            in_mode  = 3'($urandom_range(0, 7));
            tick();
        end
    endtask

    task automatic send_beat(input logic [W-1:0] data, input logic last, input logic [2:0] mode);
        int t;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        in_mode  = mode;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Later beats carry a random mode, which the unit must ignore.
    task automatic send_frame(input logic [2:0] mode, input int n, input word_arr_t d, input bit bubbles);
        logic last;
        for (int i = 0; i < n; i++) begin
            if (bubbles && i > 0) idle_cycles($urandom_range(0, 2));
            if (i == n - 1) last = (n == B) ? 1'($urandom_range(0, 1)) : 1'b1;
            else            last = 1'b0;
            send_beat(d[i], last, (i == 0) ? mode : 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic check_result(input string tag, input logic eb, input logic [W-1:0] ew,
                                input int ebeats, input logic ee);
        chk($sformatf("%s.valid", tag), 32'(out_valid), 32'd1);
        chk($sformatf("%s.bit", tag), 32'(out_bit), 32'(eb));
        chk($sformatf("%s.word", tag), out_word, ew);
        chk($sformatf("%s.beats", tag), 32'(out_beats), 32'(ebeats));
        chk($sformatf("%s.err", tag), 32'(out_err), 32'(ee));
        chk($sformatf("%s.in_ready_done", tag), 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("%s.valid_clr", tag), 32'(out_valid), 32'd0);
        chk($sformatf("%s.in_ready_idle", tag), 32'(in_ready), 32'd1);
    endtask

    // Reference: scalar result from the total count of set bits across the frame.
    function automatic void model(input logic [2:0] m, input int n, input word_arr_t d,
                                  output logic b, output logic [W-1:0] w, output logic e);
        int ones;
        logic [W-1:0] and_w, or_w, xor_w;
        ones  = 0;
        and_w = '1;
        or_w  = '0;
        xor_w = '0;
        for (int i = 0; i < n; i++) begin
            ones  += $countones(d[i]);
            and_w &= d[i];
            or_w  |= d[i];
            xor_w ^= d[i];
        end
        e = 1'b0;
        case (m)
            3'd0: begin b = (ones == n * W);    w = and_w; end
            3'd1: begin b = !(ones == n * W);   w = and_w; end
            3'd2: begin b = (ones != 0);        w = or_w;  end
            3'd3: begin b = !(ones != 0);       w = or_w;  end
            3'd4: begin b = (ones % 2 == 1);    w = xor_w; end
            3'd5: begin b = !(ones % 2 == 1);   w = xor_w; end
            default: begin b = 1'b0; w = xor_w; e = 1'b1; end
        endcase
    endfunction

    task automatic add_vec(input logic [2:0] m, input int n, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3, input logic eb,
                           input logic [W-1:0] ew, input int ebeats, input logic ee);
        vec_t v;
        v.mode = m; v.n = n;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.eb = eb; v.ew = ew; v.ebeats = ebeats; v.ee = ee;
        vq.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_arr_t fd;
        logic eb, ee;
        logic [W-1:0] ew;
        int n;
        logic [2:0] m;

        add_vec(3'd4, 4, 32'h1, 32'h2, 32'h4, 32'h8, 1'b0, 32'hF, 4, 1'b0);
        add_vec(3'd5, 4, 32'h1, 32'h2, 32'h4, 32'h8, 1'b1, 32'hF, 4, 1'b0);
        add_vec(3'd2, 2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2, 1'b0);
        add_vec(3'd3, 2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 2, 1'b0);
        add_vec(3'd0, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFFFFFFF, 3, 1'b0);
        add_vec(3'd1, 1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 1, 1'b0);
        add_vec(3'd0, 2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFE, 2, 1'b0);
        add_vec(3'd6, 2, 32'hF0, 32'h0F, 32'h0, 32'h0, 1'b0, 32'hFF, 2, 1'b1);
        add_vec(3'd4, 3, 32'h7, 32'h1, 32'h0, 32'h0, 1'b0, 32'h6, 3, 1'b0);
        add_vec(3'd2, 1, 32'h80000000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h80000000, 1, 1'b0);

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_mode = '0; out_ready = 1'b0;
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_in_mode = '0; s_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; s_reset = 1'b0;

        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.bit", 32'(out_bit), 32'd0);
        chk("rst.word", out_word, 32'd0);
        chk("rst.beats", 32'(out_beats), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);

        // WIDTH=3, BEATS=1: every beat is a whole frame regardless of in_last.
        s_in_valid = 1'b1; s_in_data = 3'b111; s_in_mode = 3'd0; s_in_last = 1'b0;
        tick();
        s_in_valid = 1'b0;
        chk("small.and111.valid", 32'(s_out_valid), 32'd1);
        chk("small.and111.bit", 32'(s_out_bit), 32'd1);
        chk("small.and111.beats", 32'(s_out_beats), 32'd1);
        chk("small.and111.in_ready", 32'(s_in_ready), 32'd0);
        s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 3'b101; s_in_mode = 3'd0;
        tick();
        s_in_valid = 1'b0;
        chk("small.and101.bit", 32'(s_out_bit), 32'd0);
        chk("small.and101.word", 32'(s_out_word), 32'd5);
        s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 3'b101; s_in_mode = 3'd1;
        tick();
        s_in_valid = 1'b0;
        chk("small.nand101.bit", 32'(s_out_bit), 32'd1);
        s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;

        foreach (vq[i]) begin
            send_frame(vq[i].mode, vq[i].n, vq[i].d, 1'b1);
            check_result($sformatf("vec%0d", i), vq[i].eb, vq[i].ew, vq[i].ebeats, vq[i].ee);
        end

        // Stall in DONE while a new word waits; it must not be taken until IDLE.
        fd[0] = 32'h10; fd[1] = '0; fd[2] = '0; fd[3] = '0;
        send_frame(3'd2, 1, fd, 1'b0);
        in_valid = 1'b1; in_data = 32'h0; in_last = 1'b1; in_mode = 3'd0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stall%0d.valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d.word", c), out_word, 32'h10);
            chk($sformatf("stall%0d.bit", c), 32'(out_bit), 32'd1);
            chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall.after_hs.valid", 32'(out_valid), 32'd0);
        chk("stall.after_hs.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_result("stall.next", 1'b0, 32'h0, 1, 1'b0);

        // Reset mid-frame discards the partial frame.
        send_beat(32'h0, 1'b0, 3'd0);
        send_beat(32'h0, 1'b0, 3'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.valid", 32'(out_valid), 32'd0);
        chk("midrst.beats", 32'(out_beats), 32'd0);
        for (int i = 0; i < B; i++) fd[i] = '1;
        send_frame(3'd1, 4, fd, 1'b0);
        check_result("midrst.next", 1'b0, 32'hFFFFFFFF, 4, 1'b0);

        // Illegal mode flags the frame; a following legal frame clears the flag.
        fd[0] = 32'hFFFFFFFF;
        send_frame(3'd7, 1, fd, 1'b0);
        check_result("illegal", 1'b0, 32'hFFFFFFFF, 1, 1'b1);
        fd[0] = 32'h5;
        send_frame(3'd0, 1, fd, 1'b0);
        check_result("legal_after", 1'b0, 32'h5, 1, 1'b0);

        // Single random words through every legal mode: inverted ops equal !base.
        for (int k = 0; k < 8; k++) begin
            fd[0] = (k == 0) ? 32'hFFFFFFFF : (k == 1) ? 32'h0 : W'($urandom);
            for (int mm = 0; mm < 6; mm++) begin
                model(3'(mm), 1, fd, eb, ew, ee);
                send_frame(3'(mm), 1, fd, 1'b0);
                check_result($sformatf("single%0d_m%0d", k, mm), eb, ew, 1, ee);
            end
        end

        for (int r = 0; r < 60; r++) begin
            m = 3'($urandom_range(0, 7));
            n = $urandom_range(1, B);
            for (int i = 0; i < B; i++) begin
                case ($urandom_range(0, 3))
                    0:       fd[i] = '1;
                    1:       fd[i] = '0;
                    2:       fd[i] = W'(1) << $urandom_range(0, W - 1);
                    default: fd[i] = W'($urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0) for (int i = 0; i < B; i++) fd[i] = '1;
            model(m, n, fd, eb, ew, ee);
            send_frame(m, n, fd, 1'b1);
            check_result($sformatf("rand%0d", r), eb, ew, n, ee);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
